bus2_arbiter: RTL and testbench
===============================

BUS2_ARBITER -- requirements
Module: bus2_arbiter

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 14, the bus2 line-address width.
REQ-002 The module SHALL take parameter DATA_W, default 16, the bus2 data width.
REQ-003 The module SHALL take parameter BEATS, default 8, the data beats per cache line.
REQ-004 The module SHALL take parameter TIMEOUT, default 200, the maximum cycles spent waiting for a MemCTR response.
REQ-005 The module SHALL have one clock, CLK, with all state updating on its rising edge; reset is RESET, asynchronous and active-high.
REQ-006 Ports, as name, direction, width, meaning:
- CLK in 1: clock.
- RESET in 1: async active-high reset.
- req in 2: per-requester transaction request, level.
- wr in 2: per requester, 1 = write line, 0 = read line.
- addr0, addr1 in ADDR_W: requester line addresses.
- wdata0, wdata1 in DATA_W: write beat of the granted requester.
- gnt out 2: one-hot grant.
- beat_rdy out 1: current write beat is consumed this cycle.
- beat_valid out 1: rdata holds a valid read beat.
- rdata out DATA_W: read beat.
- done out 2: one-cycle completion pulse.
- err out 2: one-cycle timeout pulse.
- c2_out out 2: command to MemCTR.
- a2_out out ADDR_W: address to MemCTR.
- d2_out out DATA_W: write data to MemCTR.
- d2_oe out 1: d2_out drive enable.
- c2_in in 2: MemCTR command/response.
- d2_in in DATA_W: MemCTR read data.

Function
REQ-007 The C2 encoding SHALL be C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
REQ-008 The FSM SHALL have the states IDLE, WRITE, WAIT, READ and DONE.
REQ-009 In IDLE with req!=0, the arbiter SHALL register the winner's gnt, wr and addr and enter WRITE (wr=1) or WAIT (wr=0) next cycle; gnt remains asserted until IDLE is re-entered.
REQ-010 Arbitration SHALL be round-robin on a last-served pointer: when both requesters request, the one not last served wins; a single requester always wins.
REQ-011 Read: on the first WAIT cycle, c2_out=C2_READ_LINE and a2_out=addr; thereafter c2_out=C2_NOP and d2_oe=0.
REQ-012 Read: the first cycle with c2_in==C2_RESPONSE SHALL carry beat 0; the module enters READ and takes BEATS consecutive beats.
REQ-013 Read: each beat SHALL give beat_valid=1 and rdata=d2_in combinationally in the same cycle.
REQ-014 WRITE SHALL last BEATS cycles with c2_out=C2_WRITE_LINE, a2_out=addr, d2_oe=1 and d2_out=the granted wdata.
REQ-015 Each WRITE cycle SHALL assert beat_rdy; the requester presents the next beat on the following cycle; after the last beat the module enters WAIT with c2_out=C2_NOP.
REQ-016 In a write WAIT, a single C2_RESPONSE cycle SHALL complete the transaction.
REQ-017 A beat counter of width clog2(BEATS) SHALL wrap to 0 at BEATS-1; it is zeroed on every state entry.
REQ-018 The WAIT counter SHALL count cycles spent in WAIT; at TIMEOUT it pulses err[granted] and returns to IDLE without done.
REQ-019 DONE SHALL last one cycle: done[granted]=1, the last-served pointer updates, and gnt clears on the next cycle.
REQ-020 The pointer SHALL also update on timeout.
REQ-021 req deasserting mid-transaction SHALL be ignored; the transaction completes.
REQ-022 wr and addr changes after grant SHALL be ignored.
REQ-023 Back-to-back transactions SHALL be separated by exactly one IDLE cycle.
REQ-024 C2_RESPONSE outside WAIT or READ SHALL be ignored.
REQ-025 A READ beat with c2_in!=C2_RESPONSE SHALL be a protocol error: err pulse and return to IDLE.

Reset
REQ-026 RESET SHALL immediately force state=IDLE, gnt=0, done=0, err=0, beat_rdy=0, beat_valid=0, c2_out=C2_NOP, a2_out=0, d2_out=0, d2_oe=0, both counters=0 and pointer=requester 1 (so requester 0 wins first).
REQ-027 RESET mid-transaction SHALL abort it without done or err.

Structure
REQ-028 The C2 encoding and the state typedef SHALL live in the shared bus2 package, which MemCTR also uses.
REQ-029 The round-robin arbiter SHALL be a sub-module rr_arb2 (req, last-served pointer -> one-hot winner); sequencing stays in bus2_arbiter.

Verification
REQ-030 The bench SHALL cover: req=01, wr0=0, addr0=0x0123; response after 5 cycles with beats 0xA0..0xA7 -> c2_out=2 for one cycle, 8 beat_valid pulses with matching rdata, done=01.
REQ-031 The bench SHALL cover: req=10, wr1=1, addr1=0x3FFF, beats 0x11..0x18 -> 8 cycles c2_out=3 with d2_oe=1 and in-order d2_out, a single response, done=10.
REQ-032 The bench SHALL cover: req=11 held for 4 transactions -> grants 01, 10, 01, 10, each gap exactly one IDLE cycle.
REQ-033 The bench SHALL cover: read with no response -> err pulses after 200 WAIT cycles, no done, next request granted normally.
REQ-034 The bench SHALL cover: RESET asserted at write beat 3 -> all outputs at reset values before the next edge, c2_out=0, no done.
REQ-035 The bench SHALL cover: req0 dropped during READ -> all 8 beats delivered and done=01.

Source files
------------

// File: rtl/bus2_pkg.sv
// Shared bus2 definitions: C2 command encoding and the arbiter state type.
// MemCTR imports this package as well.
package bus2_pkg;

   localparam logic [1:0] C2_NOP        = 2'd0;
   localparam logic [1:0] C2_RESPONSE   = 2'd1;
   localparam logic [1:0] C2_READ_LINE  = 2'd2;
   localparam logic [1:0] C2_WRITE_LINE = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WAIT,
      READ,
      DONE
   } bus2_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester not served last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      if (req == 2'b11) begin
         win = last ? 2'b01 : 2'b10;
      end else begin
         win = req;
      end
   end

endmodule

// File: rtl/bus2_arbiter.sv
// Arbitrates two line requesters onto bus2 and sequences whole-line reads and
// writes to MemCTR, with a response timeout and read-beat protocol checking.
module bus2_arbiter
   import bus2_pkg::*;
#(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned BEATS   = 8,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [1:0]        req,
   input  logic [1:0]        wr,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic              beat_rdy,
   output logic              beat_valid,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        done,
   output logic [1:0]        err,
   output logic [1:0]        c2_out,
   output logic [ADDR_W-1:0] a2_out,
   output logic [DATA_W-1:0] d2_out,
   output logic              d2_oe,
   input  logic [1:0]        c2_in,
   input  logic [DATA_W-1:0] d2_in
);

   localparam int unsigned BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned WCW = $clog2(TIMEOUT + 1);
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
   // Beat 0 arrives with the response seen in WAIT, so READ holds BEATS-1 beats.
   localparam logic [BCW-1:0] READ_LAST = BCW'(BEATS - 2);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   bus2_state_e       state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              last_q, last_d;
   logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
   logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [1:0]        win;

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .last (last_q),
      .win  (win)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         gnt_q      <= 2'b00;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         last_q     <= 1'b1;
         beat_cnt_q <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      wait_cnt_d = wait_cnt_q;
      beat_rdy   = 1'b0;
      beat_valid = 1'b0;
      rdata      = '0;
      done       = 2'b00;
      err        = 2'b00;
      c2_out     = C2_NOP;
      a2_out     = '0;
      d2_out     = '0;
      d2_oe      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               gnt_d      = win;
               wr_d       = win[1] ? wr[1] : wr[0];
               addr_d     = win[1] ? addr1 : addr0;
               state_d    = wr_d ? WRITE : WAIT;
               beat_cnt_d = '0;
               wait_cnt_d = '0;
            end
         end

         WRITE: begin
            c2_out   = C2_WRITE_LINE;
            a2_out   = addr_q;
            d2_oe    = 1'b1;
            d2_out   = gnt_q[1] ? wdata1 : wdata0;
            beat_rdy = 1'b1;
            if (beat_cnt_q == BEAT_LAST) begin
               beat_cnt_d = '0;
               wait_cnt_d = '0;
               state_d    = WAIT;
            end else begin
               beat_cnt_d = beat_cnt_q + BCW'(1);
            end
         end

         WAIT: begin
            if (!wr_q && wait_cnt_q == '0) begin
               c2_out = C2_READ_LINE;
               a2_out = addr_q;
            end
            if (c2_in == C2_RESPONSE) begin
               if (wr_q) begin
                  state_d = DONE;
               end else begin
                  beat_valid = 1'b1;
                  rdata      = d2_in;
                  state_d    = READ;
               end
               beat_cnt_d = '0;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               err        = gnt_q;
               gnt_d      = 2'b00;
               last_d     = gnt_q[1];
               wait_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end

         READ: begin
            if (c2_in == C2_RESPONSE) begin
               beat_valid = 1'b1;
               rdata      = d2_in;
               if (beat_cnt_q == READ_LAST) begin
                  beat_cnt_d = '0;
                  state_d    = DONE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BCW'(1);
               end
            end else begin
               // MemCTR broke the beat stream: abandon the line.
               err        = gnt_q;
               gnt_d      = 2'b00;
               last_d     = gnt_q[1];
               beat_cnt_d = '0;
               state_d    = IDLE;
            end
         end

         DONE: begin
            done    = gnt_q;
            gnt_d   = 2'b00;
            last_d  = gnt_q[1];
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign gnt = gnt_q;

endmodule

// File: tb/tb_bus2_arbiter.sv
// Self-checking bench for bus2_arbiter: directed scenarios with randomized data,
// checked against a transaction-level model of the arbitration and bus timing.
module tb_bus2_arbiter;

   localparam logic [1:0] NOP  = 2'd0;
   localparam logic [1:0] RESP = 2'd1;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  req, wr;
   logic [13:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [1:0]  gnt;
   logic        beat_rdy, beat_valid;
   logic [15:0] rdata;
   logic [1:0]  done, err;
   logic [1:0]  c2_out;
   logic [13:0] a2_out;
   logic [15:0] d2_out;
   logic        d2_oe;
   logic [1:0]  c2_in;
   logic [15:0] d2_in;

   int checks   = 0;
   int failures = 0;
   int last_srv = 1;

   bus2_arbiter dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .req        (req),
      .wr         (wr),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .gnt        (gnt),
      .beat_rdy   (beat_rdy),
      .beat_valid (beat_valid),
      .rdata      (rdata),
      .done       (done),
      .err        (err),
      .c2_out     (c2_out),
      .a2_out     (a2_out),
      .d2_out     (d2_out),
      .d2_oe      (d2_oe),
      .c2_in      (c2_in),
      .d2_in      (d2_in)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Winner from the round-robin rule: contention goes to the one not served last.
   function automatic int pick(input logic [1:0] r);
      if (r == 2'b11) return (last_srv == 1) ? 0 : 1;
      return (r == 2'b01) ? 0 : 1;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"},  32'(gnt), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"},  32'(err), 0);
      chk({tag, "_rdy"},  32'(beat_rdy), 0);
      chk({tag, "_bv"},   32'(beat_valid), 0);
      chk({tag, "_c2"},   32'(c2_out), 0);
      chk({tag, "_a2"},   32'(a2_out), 0);
      chk({tag, "_d2"},   32'(d2_out), 0);
      chk({tag, "_oe"},   32'(d2_oe), 0);
   endtask

   // One transaction, entered in the IDLE cycle where req is first presented.
   task automatic txn(input logic [1:0] rq, input logic [1:0] wrv,
                      input logic [13:0] a0, input logic [13:0] a1,
                      input logic [15:0] base, input bit seq, input int delay,
                      input bit no_resp, input bit drop, input int rst_beat);
      int          w;
      logic [1:0]  oh;
      logic [13:0] ea;
      logic        is_wr;
      logic [15:0] bt [8];
      for (int k = 0; k < 8; k++) bt[k] = seq ? 16'(base + 16'(k)) : 16'($urandom);
      w     = pick(rq);
      oh    = (w == 1) ? 2'b10 : 2'b01;
      ea    = (w == 1) ? a1 : a0;
      is_wr = wrv[w];

      req = rq; wr = wrv; addr0 = a0; addr1 = a1; c2_in = NOP;
      @(negedge CLK);
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_c2", 32'(c2_out), 0);
      tick();
      // Post-grant changes on wr/addr must not matter.
      wr = ~wrv; addr0 = 14'($urandom); addr1 = 14'($urandom);

      if (is_wr) begin
         for (int k = 0; k < 8; k++) begin
            if (w == 1) begin wdata1 = bt[k]; wdata0 = 16'($urandom); end
            else        begin wdata0 = bt[k]; wdata1 = 16'($urandom); end
            if (k == rst_beat) begin
               RESET = 1'b1;
               #1;
               chk_reset_vals("rst_mid");
               tick();
               RESET = 1'b0; req = 2'b00;
               @(negedge CLK);
               chk("post_rst_done", 32'(done), 0);
               chk("post_rst_err", 32'(err), 0);
               tick();
               last_srv = 1;
               return;
            end
            @(negedge CLK);
            chk("wr_gnt", 32'(gnt), 32'(oh));
            chk("wr_c2", 32'(c2_out), 3);
            chk("wr_oe", 32'(d2_oe), 1);
            chk("wr_a2", 32'(a2_out), 32'(ea));
            chk("wr_d2", 32'(d2_out), 32'(bt[k]));
            chk("wr_rdy", 32'(beat_rdy), 1);
            tick();
         end
         for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            chk("wwait_c2", 32'(c2_out), 0);
            chk("wwait_oe", 32'(d2_oe), 0);
            chk("wwait_done", 32'(done), 0);
            tick();
         end
         c2_in = RESP;
         @(negedge CLK);
         chk("wresp_done", 32'(done), 0);
         tick();
         // A stray response in DONE must be ignored.
         @(negedge CLK);
         chk("wdone", 32'(done), 32'(oh));
         chk("wdone_err", 32'(err), 0);
         chk("wdone_gnt", 32'(gnt), 32'(oh));
         tick();
         c2_in = NOP;
         last_srv = w;
         return;
      end

      for (int i = 0; i < (no_resp ? 200 : delay); i++) begin
         c2_in = NOP; d2_in = 16'($urandom);
         @(negedge CLK);
         chk("rwait_c2", 32'(c2_out), (i == 0) ? 2 : 0);
         if (i == 0) chk("rwait_a2", 32'(a2_out), 32'(ea));
         chk("rwait_oe", 32'(d2_oe), 0);
         chk("rwait_bv", 32'(beat_valid), 0);
         chk("rwait_done", 32'(done), 0);
         chk("rwait_err", 32'(err), (no_resp && i == 199) ? 32'(oh) : 0);
         tick();
      end
      if (no_resp) begin
         last_srv = w;
         return;
      end
      for (int k = 0; k < 8; k++) begin
         c2_in = RESP; d2_in = bt[k];
         if (drop && k == 2) req = 2'b00;
         @(negedge CLK);
         chk("rd_bv", 32'(beat_valid), 1);
         chk("rd_data", 32'(rdata), 32'(bt[k]));
         chk("rd_c2", 32'(c2_out), 0);
         chk("rd_err", 32'(err), 0);
         chk("rd_gnt", 32'(gnt), 32'(oh));
         tick();
      end
      c2_in = NOP;
      @(negedge CLK);
      chk("rdone", 32'(done), 32'(oh));
      chk("rdone_err", 32'(err), 0);
      chk("rdone_bv", 32'(beat_valid), 0);
      tick();
      last_srv = w;
   endtask

   initial begin
      RESET = 1'b1; req = 2'b00; wr = 2'b00; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; c2_in = NOP; d2_in = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_reset_vals("reset");
      tick();
      RESET = 1'b0;
      tick();

      // Read line from requester 0, response 5 cycles after the command.
      txn(2'b01, 2'b00, 14'h0123, 14'($urandom), 16'hA0, 1'b1, 5, 1'b0, 1'b0, -1);
      // Write line from requester 1 at the top address.
      txn(2'b10, 2'b10, 14'($urandom), 14'h3FFF, 16'h11, 1'b1, 3, 1'b0, 1'b0, -1);
      // Continuous contention alternates grants with a single IDLE gap.
      for (int t = 0; t < 4; t++)
         txn(2'b11, 2'($urandom), 14'($urandom), 14'($urandom), 16'h0, 1'b0,
             int'($urandom_range(1, 6)), 1'b0, 1'b0, -1);
      // Read that never gets a response, then a normal transaction.
      txn(2'b01, 2'b00, 14'($urandom), 14'($urandom), 16'h0, 1'b0, 0, 1'b1, 1'b0, -1);
      txn(2'b11, 2'($urandom), 14'($urandom), 14'($urandom), 16'h0, 1'b0, 2, 1'b0, 1'b0, -1);
      // Reset in the middle of a write.
      txn(2'b10, 2'b10, 14'($urandom), 14'($urandom), 16'h0, 1'b0, 1, 1'b0, 1'b0, 3);
      // Requester 0 withdraws req during its read.
      txn(2'b01, 2'b00, 14'($urandom), 14'($urandom), 16'h0, 1'b0, 2, 1'b0, 1'b1, -1);
      // Random mix.
      for (int t = 0; t < 6; t++) begin
         logic [1:0] r;
         r = 2'($urandom_range(1, 3));
         txn(r, 2'($urandom), 14'($urandom), 14'($urandom), 16'h0, 1'b0,
             int'($urandom_range(1, 8)), 1'b0, 1'b0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
